// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, driving the datapath strobes combinationally.
module multicycle_ctrl #(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         instr,
  input  logic                alu_zero,
  input  logic                mem_ack,
  output logic                pc_we,
  output logic                pc_src,
  output logic                ir_we,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic [3:0]          alu_op,
  output logic                alu_src_b,
  output logic                rf_we,
  output logic                rf_wsel,
  output logic                halted,
  output logic                illegal_op,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;

  state_t              r_state;
  state_t              w_next;
  logic [RETIRE_W-1:0] r_retired;

  logic [3:0] w_opcode;
  logic [3:0] w_funct;
  logic       w_retire;
  logic       w_pc_we;
  logic       w_pc_src;
  logic       w_ir_we;
  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_mem_addr_sel;
  logic [3:0] w_alu_op;
  logic       w_alu_src_b;
  logic       w_rf_we;
  logic       w_rf_wsel;
  logic       w_illegal;
  logic       w_unused_instr;

  assign w_opcode = instr[31:28];
  assign w_funct  = instr[3:0];
  // Register specifiers and immediate are consumed by the datapath, not here.
  assign w_unused_instr = ^instr[27:4];

  function automatic logic is_legal(input logic [3:0] op);
    is_legal = (op == OP_RTYPE) || (op == OP_ADDI) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_BEQ) || (op == OP_HALT);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) begin
        r_retired <= r_retired + RETIRE_W'(1);
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    w_retire       = 1'b0;
    w_pc_we        = 1'b0;
    w_pc_src       = 1'b0;
    w_ir_we        = 1'b0;
    w_mem_req      = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_alu_op       = ALU_ADD;
    w_alu_src_b    = 1'b0;
    w_rf_we        = 1'b0;
    w_rf_wsel      = 1'b0;
    w_illegal      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (mem_ack) begin
          w_ir_we = 1'b1;
          w_pc_we = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: begin
        if (w_opcode == OP_HALT) begin
          w_next = S_HALT;
        end else if (!is_legal(w_opcode)) begin
          w_illegal = 1'b1;
          w_next    = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (w_opcode)
          OP_RTYPE: begin
            w_alu_op = w_funct;
            w_next   = S_WB;
          end
          OP_ADDI: begin
            w_alu_op    = ALU_ADD;
            w_alu_src_b = 1'b1;
            w_next      = S_WB;
          end
          OP_LW, OP_SW: begin
            w_alu_op    = ALU_ADD;
            w_alu_src_b = 1'b1;
            w_next      = S_MEM;
          end
          OP_BEQ: begin
            w_alu_op = ALU_SUB;
            if (alu_zero) begin
              w_pc_we  = 1'b1;
              w_pc_src = 1'b1;
            end
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          // IR changed under the sequencer: resynchronise without retiring.
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_mem_req      = 1'b1;
        w_mem_addr_sel = 1'b1;
        w_mem_we       = (w_opcode == OP_SW);
        w_alu_op       = ALU_ADD;
        w_alu_src_b    = 1'b1;
        if (mem_ack) begin
          if (w_opcode == OP_LW) begin
            w_next = S_WB;
          end else begin
            w_retire = (w_opcode == OP_SW);
            w_next   = S_FETCH;
          end
        end
      end
      S_WB: begin
        w_rf_we   = 1'b1;
        w_rf_wsel = (w_opcode == OP_LW);
        w_retire  = 1'b1;
        w_next    = S_FETCH;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Reset masks every output so an in-flight request or write never leaks out.
  assign pc_we        = w_pc_we        & ~rst;
  assign pc_src       = w_pc_src       & ~rst;
  assign ir_we        = w_ir_we        & ~rst;
  assign mem_req      = w_mem_req      & ~rst;
  assign mem_we       = w_mem_we       & ~rst;
  assign mem_addr_sel = w_mem_addr_sel & ~rst;
  assign alu_op       = rst ? 4'h0 : w_alu_op;
  assign alu_src_b    = w_alu_src_b    & ~rst;
  assign rf_we        = w_rf_we        & ~rst;
  assign rf_wsel      = w_rf_wsel      & ~rst;
  assign illegal_op   = w_illegal      & ~rst;
  assign halted       = (r_state == S_HALT) & ~rst;
  assign state        = rst ? 3'd0 : r_state;
  assign retired      = rst ? '0 : r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares state and strobes against hand-computed tables.
module tb_multicycle_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        alu_zero;
  logic        mem_ack;
  logic        pc_we;
  logic        pc_src;
  logic        ir_we;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic [3:0]  alu_op;
  logic        alu_src_b;
  logic        rf_we;
  logic        rf_wsel;
  logic        halted;
  logic        illegal_op;
  logic [2:0]  state;
  logic [31:0] retired;

  logic [13:0] strb;
  logic [31:0] exp_ret;
  int          n_cmp;
  int          n_fail;

  // {pc_we,pc_src,ir_we,mem_req,mem_we,mem_addr_sel}_{alu_op}_{src_b,rf_we,rf_wsel,illegal}
  localparam logic [13:0] SB_NONE   = 14'b000000_0000_0000;
  localparam logic [13:0] SB_FWAIT  = 14'b000100_0000_0000;
  localparam logic [13:0] SB_FACK   = 14'b101100_0000_0000;
  localparam logic [13:0] SB_EX_IMM = 14'b000000_0000_1000;
  localparam logic [13:0] SB_WB_ALU = 14'b000000_0000_0100;
  localparam logic [13:0] SB_WB_MEM = 14'b000000_0000_0110;

  multicycle_ctrl #(.RETIRE_W(32)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ack(mem_ack),
    .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .alu_op(alu_op),
    .alu_src_b(alu_src_b), .rf_we(rf_we), .rf_wsel(rf_wsel), .halted(halted),
    .illegal_op(illegal_op), .state(state), .retired(retired)
  );

  assign strb = {pc_we, pc_src, ir_we, mem_req, mem_we, mem_addr_sel,
                 alu_op, alu_src_b, rf_we, rf_wsel, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; mem_ack = 1'b1; instr = 32'hF000_0000; alu_zero = 1'b1;
    n_cmp++;
    if (strb !== SB_NONE || halted !== 1'b0 || state !== 3'd0 || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_force: strobes=%b halted=%b state=%0d retired=%0d, required all zero",
               strb, halted, state, retired);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b0; instr = 32'h0; alu_zero = 1'b0;
    #4;
    n_cmp++;
    if (state !== 3'd0 || strb !== SB_NONE || retired !== 32'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: state=%0d strobes=%b retired=%0d, required state=0 strobes=0 retired=0",
               state, strb, retired);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (state !== 3'd1 || strb !== SB_FWAIT || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_fetch: state=%0d strobes=%b retired=%0d, required state=1 strobes=%b retired=0",
               state, strb, retired, SB_FWAIT);
    end
  endtask

  // mem_ack held high outside FETCH to confirm it is ignored there.
  task automatic test_rtype();
    logic        ack [4];
    logic [2:0]  st  [4];
    logic [13:0] sb  [4];
    ack = '{1'b1, 1'b1, 1'b1, 1'b1};
    st  = '{3'd1, 3'd2, 3'd3, 3'd5};
    sb  = '{SB_FACK, SB_NONE, 14'b000000_0011_0000, SB_WB_ALU};
    instr = 32'h0000_0003; alu_zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = ack[i]; #4;
      n_cmp++;
      if (state !== st[i] || strb !== sb[i]) begin
        n_fail++;
        $display("FAIL rtype cyc%0d: state=%0d strobes=%b, required state=%0d strobes=%b",
                 i + 1, state, strb, st[i], sb[i]);
      end
      @(posedge clk); #1;
    end
    exp_ret = exp_ret + 32'd1;
    n_cmp++;
    if (retired !== exp_ret || state !== 3'd1) begin
      n_fail++;
      $display("FAIL rtype_retire: retired=%0d state=%0d, required retired=%0d state=1",
               retired, state, exp_ret);
    end
  endtask

  task automatic test_addi();
    logic        ack [4];
    logic [2:0]  st  [4];
    logic [13:0] sb  [4];
    ack = '{1'b1, 1'b0, 1'b0, 1'b0};
    st  = '{3'd1, 3'd2, 3'd3, 3'd5};
    sb  = '{SB_FACK, SB_NONE, SB_EX_IMM, SB_WB_ALU};
    instr = 32'h1040_7FFF; alu_zero = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ack = ack[i]; #4;
      n_cmp++;
      if (state !== st[i] || strb !== sb[i]) begin
        n_fail++;
        $display("FAIL addi cyc%0d: state=%0d strobes=%b, required state=%0d strobes=%b",
                 i + 1, state, strb, st[i], sb[i]);
      end
      @(posedge clk); #1;
    end
    exp_ret = exp_ret + 32'd1;
    n_cmp++;
    if (retired !== exp_ret) begin
      n_fail++;
      $display("FAIL addi_retire: retired=%0d, required %0d", retired, exp_ret);
    end
  endtask

  task automatic test_lw_wait();
    logic        ack [8];
    logic [2:0]  st  [8];
    logic [13:0] sb  [8];
    ack = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    st  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
    sb  = '{SB_FACK, SB_NONE, SB_EX_IMM,
            14'b000101_0000_1000, 14'b000101_0000_1000,
            14'b000101_0000_1000, 14'b000101_0000_1000, SB_WB_MEM};
    instr = 32'h2000_0010; alu_zero = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mem_ack = ack[i]; #4;
      n_cmp++;
      if (state !== st[i] || strb !== sb[i]) begin
        n_fail++;
        $display("FAIL lw_wait cyc%0d: state=%0d strobes=%b, required state=%0d strobes=%b",
                 i + 1, state, strb, st[i], sb[i]);
      end
      @(posedge clk); #1;
    end
    exp_ret = exp_ret + 32'd1;
    n_cmp++;
    if (retired !== exp_ret || state !== 3'd1) begin
      n_fail++;
      $display("FAIL lw_retire: retired=%0d state=%0d, required retired=%0d state=1",
               retired, state, exp_ret);
    end
  endtask

  task automatic test_beq(input logic zero);
    logic        ack [3];
    logic [2:0]  st  [3];
    logic [13:0] sb  [3];
    ack = '{1'b1, 1'b0, 1'b0};
    st  = '{3'd1, 3'd2, 3'd3};
    sb  = '{SB_FACK, SB_NONE, zero ? 14'b110000_0001_0000 : 14'b000000_0001_0000};
    instr = 32'h4000_0000; alu_zero = zero;
    for (int i = 0; i < 3; i++) begin
      mem_ack = ack[i]; #4;
      n_cmp++;
      if (state !== st[i] || strb !== sb[i]) begin
        n_fail++;
        $display("FAIL beq_z%0d cyc%0d: state=%0d strobes=%b, required state=%0d strobes=%b",
                 zero, i + 1, state, strb, st[i], sb[i]);
      end
      @(posedge clk); #1;
    end
    exp_ret = exp_ret + 32'd1;
    n_cmp++;
    if (retired !== exp_ret || state !== 3'd1) begin
      n_fail++;
      $display("FAIL beq_retire: retired=%0d state=%0d, required retired=%0d state=1",
               retired, state, exp_ret);
    end
  endtask

  task automatic test_sw();
    logic        ack [4];
    logic [2:0]  st  [4];
    logic [13:0] sb  [4];
    ack = '{1'b1, 1'b0, 1'b0, 1'b1};
    st  = '{3'd1, 3'd2, 3'd3, 3'd4};
    sb  = '{SB_FACK, SB_NONE, SB_EX_IMM, 14'b000111_0000_1000};
    instr = 32'h3000_0004; alu_zero = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_ack = ack[i]; #4;
      n_cmp++;
      if (state !== st[i] || strb !== sb[i]) begin
        n_fail++;
        $display("FAIL sw cyc%0d: state=%0d strobes=%b, required state=%0d strobes=%b",
                 i + 1, state, strb, st[i], sb[i]);
      end
      @(posedge clk); #1;
    end
    exp_ret = exp_ret + 32'd1;
    n_cmp++;
    if (retired !== exp_ret || state !== 3'd1) begin
      n_fail++;
      $display("FAIL sw_retire: retired=%0d state=%0d, required retired=%0d state=1",
               retired, state, exp_ret);
    end
  endtask

  task automatic test_illegal();
    logic        ack [3];
    logic [2:0]  st  [3];
    logic [13:0] sb  [3];
    ack = '{1'b1, 1'b0, 1'b0};
    st  = '{3'd1, 3'd2, 3'd1};
    sb  = '{SB_FACK, 14'b000000_0000_0001, SB_FWAIT};
    instr = 32'h7000_0000; alu_zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = ack[i]; #4;
      n_cmp++;
      if (state !== st[i] || strb !== sb[i] || retired !== exp_ret) begin
        n_fail++;
        $display("FAIL illegal cyc%0d: state=%0d strobes=%b retired=%0d, required state=%0d strobes=%b retired=%0d",
                 i + 1, state, strb, retired, st[i], sb[i], exp_ret);
      end
      if (i < 2) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_sw_reset();
    logic        ack [3];
    logic [2:0]  st  [3];
    logic [13:0] sb  [3];
    ack = '{1'b1, 1'b0, 1'b0};
    st  = '{3'd1, 3'd2, 3'd3};
    sb  = '{SB_FACK, SB_NONE, SB_EX_IMM};
    instr = 32'h3000_0008; alu_zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_ack = ack[i]; #4;
      n_cmp++;
      if (state !== st[i] || strb !== sb[i]) begin
        n_fail++;
        $display("FAIL swrst cyc%0d: state=%0d strobes=%b, required state=%0d strobes=%b",
                 i + 1, state, strb, st[i], sb[i]);
      end
      @(posedge clk); #1;
    end
    mem_ack = 1'b0; #2;
    n_cmp++;
    if (state !== 3'd4 || strb !== 14'b000111_0000_1000 || retired !== exp_ret) begin
      n_fail++;
      $display("FAIL swrst_mem: state=%0d strobes=%b retired=%0d, required state=4 strobes=%b retired=%0d",
               state, strb, retired, 14'b000111_0000_1000, exp_ret);
    end
    // Reset and acknowledge together: reset must win.
    rst = 1'b1; mem_ack = 1'b1; #2;
    n_cmp++;
    if (strb !== SB_NONE || state !== 3'd0 || retired !== 32'd0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL swrst_force: strobes=%b state=%0d retired=%0d, required all zero",
               strb, state, retired);
    end
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b0;
    exp_ret = 32'd0;
    #4;
    n_cmp++;
    if (state !== 3'd0 || strb !== SB_NONE || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL swrst_idle: state=%0d strobes=%b retired=%0d, required state=0 strobes=0 retired=0",
               state, strb, retired);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (state !== 3'd1 || strb !== SB_FWAIT || retired !== 32'd0) begin
      n_fail++;
      $display("FAIL swrst_fetch: state=%0d strobes=%b retired=%0d, required state=1 strobes=%b retired=0",
               state, strb, retired, SB_FWAIT);
    end
  endtask

  task automatic test_halt();
    instr = 32'hF000_0000; alu_zero = 1'b0;
    mem_ack = 1'b1; #4;
    n_cmp++;
    if (state !== 3'd1 || strb !== SB_FACK) begin
      n_fail++;
      $display("FAIL halt_fetch: state=%0d strobes=%b, required state=1 strobes=%b",
               state, strb, SB_FACK);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; #4;
    n_cmp++;
    if (state !== 3'd2 || strb !== SB_NONE || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_decode: state=%0d strobes=%b halted=%b, required state=2 strobes=0 halted=0",
               state, strb, halted);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      mem_ack = i[0]; #4;
      n_cmp++;
      if (state !== 3'd6 || halted !== 1'b1 || strb !== SB_NONE || retired !== exp_ret) begin
        n_fail++;
        $display("FAIL halt_hold cyc%0d: state=%0d halted=%b strobes=%b retired=%0d, required state=6 halted=1 strobes=0 retired=%0d",
                 i, state, halted, strb, retired, exp_ret);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; exp_ret = 32'd0;
    rst = 1'b1; instr = 32'h0; alu_zero = 1'b0; mem_ack = 1'b0;
    #1;
    test_reset();
    test_rtype();
    test_addi();
    test_lw_wait();
    test_beq(1'b1);
    test_beq(1'b0);
    test_sw();
    test_illegal();
    test_sw_reset();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
